// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI read arbiter: FSM states,
// AXI response codes and the grant decision.
package axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Returns the new owner (0 = m0, 1 = m1); on a tie, round-robin favours
   // the master that was not granted last, fixed priority favours m1.
   function automatic logic arb_pick(input logic req0, input logic req1,
                                     input logic last, input logic rr);
      if (req0 && req1)
         return rr ? !last : 1'b1;
      return req1;
   endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read address/data channel bundle; master drives AR and R-ready,
// slave drives AR-ready and the R channel.
interface axi_rd_arbiter_if;

   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [1:0]  rresp;
   logic [31:0] rdata;

   modport master (
      output arvalid, araddr, rready,
      input  arready, rvalid, rresp, rdata
   );

   modport slave (
      input  arvalid, araddr, rready,
      output arready, rvalid, rresp, rdata
   );

endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master (IFU = m0, LSU = m1) AXI read arbiter onto one memory port;
// one beat per grant, grant registered one cycle after the request.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int unsigned RR = 1
) (
   input  logic             clk,
   input  logic             rst,
   axi_rd_arbiter_if.slave  m0,
   axi_rd_arbiter_if.slave  m1,
   axi_rd_arbiter_if.master s
);

   localparam logic RR_EN = (RR != 0);

   arb_state_e state;
   logic       owner;
   logic       last;

   logic        own_arvalid;
   logic [31:0] own_araddr;
   logic        own_rready;

   assign own_arvalid = owner ? m1.arvalid : m0.arvalid;
   assign own_araddr  = owner ? m1.araddr  : m0.araddr;
   assign own_rready  = owner ? m1.rready  : m0.rready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ARB_IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (m0.arvalid || m1.arvalid) begin
                  owner <= arb_pick(m0.arvalid, m1.arvalid, last, RR_EN);
                  state <= ARB_ADDR;
               end
            end
            ARB_ADDR: begin
               // s.arvalid mirrors own_arvalid here, so a dropped request
               // can never complete the address handshake.
               if (own_arvalid && s.arready)
                  state <= ARB_DATA;
               else if (!own_arvalid)
                  state <= ARB_IDLE;
            end
            ARB_DATA: begin
               if (s.rvalid && own_rready) begin
                  state <= ARB_IDLE;
                  last  <= owner;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   always_comb begin
      s.arvalid  = 1'b0;
      s.araddr   = '0;
      s.rready   = 1'b0;
      m0.arready = 1'b0;
      m0.rvalid  = 1'b0;
      m0.rresp   = '0;
      m0.rdata   = '0;
      m1.arready = 1'b0;
      m1.rvalid  = 1'b0;
      m1.rresp   = '0;
      m1.rdata   = '0;
      case (state)
         ARB_ADDR: begin
            s.arvalid = own_arvalid;
            s.araddr  = own_araddr;
            s.rready  = own_rready;
            if (owner) m1.arready = s.arready;
            else       m0.arready = s.arready;
         end
         ARB_DATA: begin
            s.rready = own_rready;
            if (owner) begin
               m1.rvalid = s.rvalid;
               m1.rresp  = s.rresp;
               m1.rdata  = s.rdata;
            end else begin
               m0.rvalid = s.rvalid;
               m0.rresp  = s.rresp;
               m0.rdata  = s.rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a round-robin instance is checked
// throughout, a fixed-priority instance shares the stimulus for tie grants.
module tb_axi_rd_arbiter;
   import axi_rd_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
   logic        m0_rready  = 1'b0, m1_rready  = 1'b0;
   logic [31:0] m0_araddr  = '0,   m1_araddr  = '0;
   logic        s_arready  = 1'b0, s_rvalid   = 1'b0;
   logic [1:0]  s_rresp    = '0;
   logic [31:0] s_rdata    = '0;

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;
   int unsigned hs_cnt    = 0;
   int unsigned hs_base   = 0;
   int unsigned d1, d2;

   axi_rd_arbiter_if m0a(), m1a(), sa();
   axi_rd_arbiter_if m0b(), m1b(), sb();

   assign m0a.arvalid = m0_arvalid;  assign m0b.arvalid = m0_arvalid;
   assign m0a.araddr  = m0_araddr;   assign m0b.araddr  = m0_araddr;
   assign m0a.rready  = m0_rready;   assign m0b.rready  = m0_rready;
   assign m1a.arvalid = m1_arvalid;  assign m1b.arvalid = m1_arvalid;
   assign m1a.araddr  = m1_araddr;   assign m1b.araddr  = m1_araddr;
   assign m1a.rready  = m1_rready;   assign m1b.rready  = m1_rready;
   assign sa.arready  = s_arready;   assign sb.arready  = s_arready;
   assign sa.rvalid   = s_rvalid;    assign sb.rvalid   = s_rvalid;
   assign sa.rresp    = s_rresp;     assign sb.rresp    = s_rresp;
   assign sa.rdata    = s_rdata;     assign sb.rdata    = s_rdata;

   axi_rd_arbiter #(.RR(1)) dut    (.clk(clk), .rst(rst), .m0(m0a), .m1(m1a), .s(sa));
   axi_rd_arbiter #(.RR(0)) dut_fp (.clk(clk), .rst(rst), .m0(m0b), .m1(m1b), .s(sb));

   always @(posedge clk)
      if (sa.rvalid && sa.rready) hs_cnt <= hs_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its summary, observed timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state, with inputs active so outputs would show any leak
      m0_arvalid = 1'b1; s_rvalid = 1'b1; m0_rready = 1'b1;
      #2;
      chk("rst_s_arvalid", sa.arvalid, 0);
      chk("rst_m0_arready", m0a.arready, 0);
      chk("rst_m0_rvalid", m0a.rvalid, 0);
      chk("rst_s_rready", sa.rready, 0);

      // single m0 read, memory delay 0
      #1; rst = 1'b1;
      m0_araddr = 32'h8000_0000; s_arready = 1'b1; s_rvalid = 1'b0;
      #1;
      chk("t1_no_grant_yet", sa.arvalid, 0);
      tick; #1;
      chk("t1_s_arvalid", sa.arvalid, 1);
      chk("t1_s_araddr", sa.araddr, 32'h8000_0000);
      chk("t1_m0_arready", m0a.arready, 1);
      chk("t1_m1_arready", m1a.arready, 0);
      chk("t1_s_rready_addr", sa.rready, 1);
      tick;
      m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = AXI_RESP_OKAY;
      #1;
      chk("t1_m0_rvalid", m0a.rvalid, 1);
      chk("t1_m0_rdata", m0a.rdata, 32'hDEAD_BEEF);
      chk("t1_s_arvalid_data", sa.arvalid, 0);
      chk("t1_m1_rvalid", m1a.rvalid, 0);
      chk("t1_m1_rdata", m1a.rdata, 0);
      tick;
      s_rvalid = 1'b0;
      #1;
      chk("t1_idle_m0_rvalid", m0a.rvalid, 0);
      chk("t1_idle_s_rready", sa.rready, 0);

      // simultaneous requests after reset: RR -> m0 first, fixed -> m1 first
      rst = 1'b0; #1; rst = 1'b1;
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_1000;
      m1_arvalid = 1'b1; m1_araddr = 32'h0000_2000;
      m1_rready = 1'b1; s_arready = 1'b0;
      tick; #1;
      chk("t2_rr_araddr", sa.araddr, 32'h0000_1000);
      chk("t2_fp_araddr", sb.araddr, 32'h0000_2000);
      chk("t2_rr_m0_arready_wait", m0a.arready, 0);
      s_arready = 1'b1; #1;
      chk("t2_rr_m0_arready", m0a.arready, 1);
      chk("t2_rr_m1_arready", m1a.arready, 0);
      chk("t2_fp_m1_arready", m1b.arready, 1);
      chk("t2_fp_m0_arready", m0b.arready, 0);
      tick;
      m0_arvalid = 1'b0; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'h1111_1111; s_rresp = AXI_RESP_SLVERR;
      #1;
      chk("t2_m0_rvalid", m0a.rvalid, 1);
      chk("t2_m0_rdata", m0a.rdata, 32'h1111_1111);
      chk("t2_m0_rresp", m0a.rresp, 32'(AXI_RESP_SLVERR));
      chk("t2_m1_rvalid_other", m1a.rvalid, 0);
      chk("t2_m1_rresp_other", m1a.rresp, 0);
      tick;
      s_rvalid = 1'b0; #1;
      chk("t2_grant_cycle", sa.arvalid, 0);
      tick; #1;
      chk("t2_m1_s_arvalid", sa.arvalid, 1);
      chk("t2_m1_araddr", sa.araddr, 32'h0000_2000);
      s_arready = 1'b1;
      tick;
      m1_arvalid = 1'b0; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'h2222_2222; s_rresp = AXI_RESP_OKAY;
      #1;
      chk("t2_m1_rvalid", m1a.rvalid, 1);
      chk("t2_m1_rdata", m1a.rdata, 32'h2222_2222);
      chk("t2_m0_rvalid_other", m0a.rvalid, 0);
      tick;
      s_rvalid = 1'b0;

      // both held over four transactions: m0, m1, m0, m1
      m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick; #1;
         chk("t3_araddr", sa.araddr, (i % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000);
         tick;
         s_rvalid = 1'b1; s_rdata = 32'h0000_00A0 + 32'(i);
         #1;
         if (i % 2 == 1) begin
            chk("t3_m1_rvalid", m1a.rvalid, 1);
            chk("t3_m0_rvalid", m0a.rvalid, 0);
         end else begin
            chk("t3_m0_rvalid", m0a.rvalid, 1);
            chk("t3_m1_rvalid", m1a.rvalid, 0);
         end
         tick;
         s_rvalid = 1'b0;
      end
      m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b0; m1_rready = 1'b0;

      // random memory delays, m0 withholds rready for three cycles
      d1 = $urandom_range(0, 31);
      d2 = $urandom_range(0, 31);
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_3000; m0_rready = 1'b0;
      tick;
      repeat (d1) tick;
      #1;
      chk("t4_s_arvalid_held", sa.arvalid, 1);
      s_arready = 1'b1;
      tick;
      m0_arvalid = 1'b0; s_arready = 1'b0;
      hs_base = hs_cnt;
      repeat (d2) tick;
      s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t4_m0_rvalid_stall", m0a.rvalid, 1);
         chk("t4_m0_rdata_stable", m0a.rdata, 32'hCAFE_F00D);
         chk("t4_s_rready_low", sa.rready, 0);
         tick;
      end
      m0_rready = 1'b1; #1;
      chk("t4_s_rready", sa.rready, 1);
      tick;
      s_rvalid = 1'b0; #1;
      chk("t4_one_handshake", hs_cnt - hs_base, 1);
      chk("t4_m0_rvalid_done", m0a.rvalid, 0);

      // reset during DATA; first tie afterwards goes to m0
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_4000; s_arready = 1'b1;
      tick;
      tick;
      m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h55AA_55AA;
      #1;
      chk("t5_m0_rvalid_pre", m0a.rvalid, 1);
      rst = 1'b0; #1;
      chk("t5_rst_m0_rvalid", m0a.rvalid, 0);
      chk("t5_rst_m0_rdata", m0a.rdata, 0);
      chk("t5_rst_s_rready", sa.rready, 0);
      chk("t5_rst_s_arvalid", sa.arvalid, 0);
      s_rvalid = 1'b0;
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_1000;
      m1_arvalid = 1'b1; m1_araddr = 32'h0000_2000;
      #1;
      rst = 1'b1;
      tick; #1;
      chk("t5_first_grant_m0", sa.araddr, 32'h0000_1000);

      // owner abandons ADDR before handshake; other master is granted next
      rst = 1'b0; #1; rst = 1'b1;
      hs_base = hs_cnt;
      tick; #1;
      chk("t6_m0_owner", sa.araddr, 32'h0000_1000);
      m0_arvalid = 1'b0; #1;
      chk("t6_drop_s_arvalid", sa.arvalid, 0);
      chk("t6_drop_m0_arready", m0a.arready, 0);
      tick; #1;
      chk("t6_idle_s_arvalid", sa.arvalid, 0);
      tick; #1;
      chk("t6_m1_s_arvalid", sa.arvalid, 1);
      chk("t6_m1_araddr", sa.araddr, 32'h0000_2000);
      chk("t6_m1_arready_wait", m1a.arready, 0);
      s_arready = 1'b1; #1;
      chk("t6_m1_arready", m1a.arready, 1);
      chk("t6_no_handshake", hs_cnt - hs_base, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter: RR, default 1, meaning 1 = round-robin grant, 0 = fixed priority with m1 winning.
REQ-002 clk  in  1  single clock; all state on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 m0_arvalid  in  1  read request from IFU.
REQ-005 m0_arready  out  1  IFU address accepted.
REQ-006 m0_araddr  in  32  IFU read address.
REQ-007 m0_rvalid  out  1  IFU read data valid.
REQ-008 m0_rready  in  1  IFU ready for data.
REQ-009 m0_rresp  out  2  IFU read response.
REQ-010 m0_rdata  out  32  IFU read data.
REQ-011 m1_arvalid, m1_arready, m1_araddr, m1_rvalid, m1_rready, m1_rresp, m1_rdata: same directions, widths and meanings as REQ-004..010, for the LSU.
REQ-012 s_arvalid  out  1  request to memory.
REQ-013 s_arready  in  1  memory address accepted.
REQ-014 s_araddr  out  32  memory read address.
REQ-015 s_rvalid  in  1  memory data valid.
REQ-016 s_rready  out  1  ready for memory data.
REQ-017 s_rresp  in  2  memory response.
REQ-018 s_rdata  in  32  memory data.

Function
REQ-019 FSM states: IDLE, ADDR, DATA; registers: owner (1 bit) and last (1 bit, last granted master).
REQ-020 IDLE: if exactly one master asserts arvalid, it becomes owner; if both assert, winner is !last when RR=1 and m1 when RR=0; next state ADDR; no request keeps IDLE.
REQ-021 Grant takes one cycle: no slave signal is driven in the cycle the request is first sampled in IDLE.
REQ-022 ADDR: s_arvalid = owner arvalid, s_araddr = owner araddr, owner arready = s_arready (combinational); other master arready = 0.
REQ-023 ADDR: s_rready = owner rready, so the memory sees rready at request time.
REQ-024 ADDR: s_arvalid && s_arready -> DATA; if the owner drops arvalid before the handshake, return to IDLE without a transfer.
REQ-025 DATA: s_arvalid = 0; owner rvalid/rresp/rdata = slave values; s_rready = owner rready; non-owner rvalid = 0, rdata = 0, rresp = 0.
REQ-026 DATA: s_rvalid && s_rready -> IDLE, last <= owner; exactly one beat per grant.
REQ-027 Outputs outside the states above: all valid/ready outputs 0, addr and data outputs 0.
REQ-028 A master holding arvalid through another master's transaction is granted in the IDLE cycle right after that transaction's R handshake plus the REQ-021 cycle; maximum wait is one full transaction when RR=1.
REQ-029 An arvalid asserted in the same cycle the R handshake completes is sampled only in the next IDLE cycle.
REQ-030 rresp and rdata are passed through unmodified; the block is address-agnostic.

Reset
REQ-031 Assertion of rst, including mid-transaction: state IDLE, owner 0, last 1 (m0 wins first tie), all outputs 0, asynchronously.
REQ-032 Deassertion: first grant evaluated on the first posedge with rst high.

Structure
REQ-033 Shared package holds the FSM state enum (ARB_IDLE, ARB_ADDR, ARB_DATA) and the AXI response codes (OKAY = 2'b00).
REQ-034 Single flat module; the grant decision may be a combinational function; no sub-module.

Verification
REQ-035 Only m0 reads 0x8000_0000 with memory delay 0 -> s_arvalid one cycle after the request; m0_rvalid with the memory data; m1 outputs all 0.
REQ-036 Both request at once after reset with RR=1 -> m0 served first, then m1; with RR=0 -> m1 first.
REQ-037 m1 and m0 held continuously over 4 transactions, RR=1 -> grants m0, m1, m0, m1.
REQ-038 Random memory delay 0..31 with m0_rready low for 3 cycles after rvalid -> state stays DATA, data stable, exactly one handshake.
REQ-039 rst driven low during DATA -> all outputs 0 immediately; first grant after release goes to m0.
REQ-040 Owner drops arvalid in ADDR while s_arready = 0 -> return to IDLE, no s_rready handshake, other master granted next.
